// File: rtl/wam_scr_disp_pkg.sv
// Shared constants for the score display: segment patterns (active-low {g,f,e,d,c,b,a})
// and the flash FSM state encoding.
package wam_scr_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_D0 = 7'h40;
  localparam logic [6:0] SEG_D1 = 7'h79;
  localparam logic [6:0] SEG_D2 = 7'h24;
  localparam logic [6:0] SEG_D3 = 7'h30;
  localparam logic [6:0] SEG_D4 = 7'h19;
  localparam logic [6:0] SEG_D5 = 7'h12;
  localparam logic [6:0] SEG_D6 = 7'h02;
  localparam logic [6:0] SEG_D7 = 7'h78;
  localparam logic [6:0] SEG_D8 = 7'h00;
  localparam logic [6:0] SEG_D9 = 7'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OFF  = 2'b01,
    ST_ON   = 2'b10
  } flash_st_t;

endpackage

// File: rtl/wam_seg7.sv
// Combinational BCD to 7-segment decoder; nibbles above 9 show a dash.
module wam_seg7
  import wam_scr_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/wam_scr_disp.sv
// Two-digit multiplexed score display with leading-zero blanking and a
// blink sequence whenever the score changes to a non-zero value.
module wam_scr_disp
  import wam_scr_disp_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int FLASH_TICKS = 250,
  parameter int FLASH_CNT   = 3
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] num,
  input  logic       en,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       flashing
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int PW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam int BW = $clog2(FLASH_CNT + 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_TICKS - 1);
  localparam logic [BW-1:0] BLINKS     = BW'(FLASH_CNT);

  logic [7:0]    num_q;
  logic [SW-1:0] scan_cnt;
  logic          tick;
  logic          chg;
  logic          sel;
  logic [3:0]    dig;
  logic [6:0]    dig_seg;
  logic          blank;
  flash_st_t     state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [BW-1:0] blink_left, blink_nxt;

  assign tick = (scan_cnt == SCAN_LAST);
  assign chg  = (num != num_q);

  // The slot about to be driven is the opposite of the current sel.
  assign dig   = sel ? num_q[3:0] : num_q[7:4];
  assign blank = !en || (state == ST_OFF) || (!sel && (num_q[7:4] == 4'h0));

  wam_seg7 u_seg7 (
    .bcd (dig),
    .seg (dig_seg)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      num_q    <= 8'h00;
      scan_cnt <= '0;
    end else begin
      num_q    <= num;
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sel <= 1'b0;
      seg <= SEG_BLANK;
      an  <= 2'b11;
    end else if (tick) begin
      sel <= ~sel;
      if (blank) begin
        seg <= SEG_BLANK;
        an  <= 2'b11;
      end else begin
        seg <= dig_seg;
        an  <= sel ? 2'b10 : 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      blink_left <= '0;
      flashing   <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      blink_left <= blink_nxt;
      flashing   <= (state_nxt != ST_IDLE);
    end
  end

  // A score change restarts (or cancels, for a clear) the blink sequence ahead of any tick.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    blink_nxt = blink_left;
    if (chg) begin
      phase_nxt = '0;
      if (num == 8'h00) begin
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = ST_OFF;
        blink_nxt = BLINKS;
      end
    end else if (tick) begin
      case (state)
        ST_OFF: begin
          if (phase == PHASE_LAST) begin
            state_nxt = ST_ON;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase + 1'b1;
          end
        end
        ST_ON: begin
          if (phase == PHASE_LAST) begin
            phase_nxt = '0;
            blink_nxt = blink_left - 1'b1;
            state_nxt = (blink_left == BW'(1)) ? ST_IDLE : ST_OFF;
          end else begin
            phase_nxt = phase + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wam_scr_disp.sv
// Randomized scoreboard bench for wam_scr_disp: a tick/elapsed-time model predicts
// seg/an/flashing each cycle, and a negedge monitor compares against the DUT.
module tb_wam_scr_disp;

  localparam int SCAN_DIV    = 4;
  localparam int FLASH_TICKS = 2;
  localparam int FLASH_CNT   = 2;
  localparam int FLASH_LEN   = 2 * FLASH_TICKS * FLASH_CNT;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       flashing;
  } exp_t;

  const logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  logic       clk;
  logic       clr_n;
  logic [7:0] num;
  logic       en;
  logic [6:0] seg;
  logic [1:0] an;
  logic       flashing;

  int n_checks;
  int n_fail;

  exp_t sb_q[$];

  wam_scr_disp #(
    .SCAN_DIV    (SCAN_DIV),
    .FLASH_TICKS (FLASH_TICKS),
    .FLASH_CNT   (FLASH_CNT)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .num      (num),
    .en       (en),
    .seg      (seg),
    .an       (an),
    .flashing (flashing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the display updates every SCAN_DIV-th clock since reset, slots alternate
  // starting with tens, and a flash is "elapsed ticks since the last change" with the blank
  // half-periods being the even multiples of FLASH_TICKS.
  initial begin
    logic [7:0] m_numq;
    logic [6:0] m_seg;
    logic [1:0] m_an;
    bit         m_active;
    int         m_e;
    int         m_k;
    int         m_ticks;
    bit         tick;
    bit         tens;
    bit         off_now;
    exp_t       item;
    m_numq = 8'h00; m_seg = 7'h7F; m_an = 2'b11;
    m_active = 1'b0; m_e = 0; m_k = 0; m_ticks = 0;
    forever begin
      @(posedge clk or negedge clr_n);
      if (!clr_n) begin
        m_numq = 8'h00; m_seg = 7'h7F; m_an = 2'b11;
        m_active = 1'b0; m_e = 0; m_k = 0; m_ticks = 0;
        sb_q.delete();
      end else begin
        tick    = (m_k % SCAN_DIV) == SCAN_DIV - 1;
        m_k++;
        off_now = m_active && (((m_e / FLASH_TICKS) % 2) == 0);
        if (tick) begin
          m_ticks++;
          tens = (m_ticks % 2) == 1;
          if (!en || off_now || (tens && m_numq[7:4] == 4'h0)) begin
            m_seg = 7'h7F;
            m_an  = 2'b11;
          end else begin
            m_seg = tens ? SEG_TBL[m_numq[7:4]] : SEG_TBL[m_numq[3:0]];
            m_an  = tens ? 2'b01 : 2'b10;
          end
        end
        if (num != m_numq) begin
          m_active = (num != 8'h00);
          m_e      = 0;
        end else if (tick && m_active) begin
          m_e++;
          if (m_e == FLASH_LEN) m_active = 1'b0;
        end
        m_numq = num;
        item.seg      = m_seg;
        item.an       = m_an;
        item.flashing = m_active;
        sb_q.push_back(item);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("seg", {1'b0, seg}, {1'b0, e.seg});
        checkOutput("an", {6'b0, an}, {6'b0, e.an});
        checkOutput("flashing", {7'b0, flashing}, {7'b0, e.flashing});
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] n, input logic e, input int hold);
    num = n;
    en  = e;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    #1 clr_n = 1'b0;
    #1;
    checkOutput("rst_seg", {1'b0, seg}, 8'h7F);
    checkOutput("rst_an", {6'b0, an}, 8'h03);
    checkOutput("rst_flashing", {7'b0, flashing}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  initial begin
    int r;
    logic [7:0] n;
    n_checks = 0;
    n_fail   = 0;
    clr_n = 1'b0;
    num   = 8'h00;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_seg", {1'b0, seg}, 8'h7F);
    checkOutput("init_an", {6'b0, an}, 8'h03);
    checkOutput("init_flashing", {7'b0, flashing}, 8'h00);
    clr_n = 1'b1;

    applyStimulus(8'h47, 1'b1, 80);
    applyStimulus(8'h05, 1'b1, 60);
    applyStimulus(8'h0C, 1'b1, 60);
    applyStimulus(8'h00, 1'b1, 20);
    applyStimulus(8'h01, 1'b1, 13);
    applyStimulus(8'h02, 1'b1, 20);
    applyStimulus(8'h00, 1'b1, 20);
    applyStimulus(8'h99, 1'b0, 50);
    applyStimulus(8'h99, 1'b1, 30);
    applyStimulus(8'h36, 1'b1, 7);
    applyReset();
    applyStimulus(8'h36, 1'b1, 50);

    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)      n = 8'h00;
      else if (r < 45) n = {4'h0, 4'($urandom_range(0, 15))};
      else if (r < 80) n = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else             n = 8'($urandom);
      applyStimulus(n, ($urandom_range(0, 99) < 85), int'($urandom_range(1, 40)));
      if ($urandom_range(0, 99) < 4) applyReset();
    end

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
